// File: rtl/tps_tick_gen_if.sv
// Step-burst command channel between the host and tps_tick_gen.
// The host drives the request; the generator reports readiness and burst progress.
interface tps_tick_gen_if #(
    parameter int STEP_WIDTH = 16
);
    logic                  i_step_valid;
    logic [STEP_WIDTH-1:0] i_step_count;
    logic                  o_step_ready;
    logic                  o_busy;
    logic                  o_done;
    logic [STEP_WIDTH-1:0] o_steps_left;

    modport master (
        output i_step_valid,
        output i_step_count,
        input  o_step_ready,
        input  o_busy,
        input  o_done,
        input  o_steps_left
    );

    modport slave (
        input  i_step_valid,
        input  i_step_count,
        output o_step_ready,
        output o_busy,
        output o_done,
        output o_steps_left
    );
endinterface

// File: rtl/tps_tick_gen.sv
// Multi-mode redstone tick generator: a phase accumulator produces tick strobes
// in RUN, counted bursts in STEP, a tick every cycle in MAX, and holds in STOP.
module tps_tick_gen #(
    parameter int ACC_WIDTH  = 32,
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ACC_WIDTH-1:0] i_tps,
    input  logic [1:0]           i_mode,
    input  logic                 i_cnt_clr,
    output logic                 o_tick,
    output logic                 o_tick_clk,
    output logic [CNT_WIDTH-1:0] o_tick_count,
    tps_tick_gen_if.slave        io_step
);

    typedef enum logic [1:0] {
        MODE_STOP = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_MAX  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    mode_t                 w_mode;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH:0]    w_sum;
    logic                  w_carry;
    logic                  w_stepMode;
    logic                  w_inBurst;
    logic                  w_advance;
    logic                  w_accept;
    logic                  w_lastTick;
    logic                  w_tickNext;
    logic                  w_stepReady;
    logic                  w_busy;
    logic                  r_tick;
    logic                  r_tickClk;
    logic                  r_done;
    logic [STEP_WIDTH-1:0] r_stepsLeft;
    logic [CNT_WIDTH-1:0]  r_count;

    assign w_mode     = mode_t'(i_mode);
    assign w_stepMode = (w_mode == MODE_STEP);
    assign w_inBurst  = (r_state == ST_BURST);
    assign w_advance  = (w_mode == MODE_RUN) || (w_stepMode && w_inBurst);
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_tps};
    assign w_carry    = w_sum[ACC_WIDTH];
    assign w_accept   = io_step.i_step_valid && w_stepReady;
    assign w_lastTick = w_stepMode && w_inBurst && w_carry
                        && (r_stepsLeft == STEP_WIDTH'(1));
    assign w_tickNext = (w_mode == MODE_MAX) || (w_advance && w_carry);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leaving STEP mid-burst aborts back to IDLE; a zero-count request never leaves IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (io_step.i_step_count != '0)) begin
                    w_nextState = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!w_stepMode || w_lastTick) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stepReady = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE:  w_stepReady = w_stepMode && !i_rst;
            ST_BURST: w_busy      = 1'b1;
            default: begin
                w_stepReady = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_tickClk   <= 1'b0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_stepsLeft <= '0;
            r_count     <= '0;
        end else begin
            if (w_advance) begin
                r_acc     <= w_sum[ACC_WIDTH-1:0];
                r_tickClk <= r_acc[ACC_WIDTH-1];
            end

            r_tick <= w_tickNext;
            r_done <= (w_accept && (io_step.i_step_count == '0)) || w_lastTick;

            if (w_accept) begin
                r_stepsLeft <= io_step.i_step_count;
            end else if (w_inBurst && !w_stepMode) begin
                r_stepsLeft <= '0;
            end else if (w_inBurst && w_carry) begin
                r_stepsLeft <= r_stepsLeft - STEP_WIDTH'(1);
            end

            // A clear wins over a tick on the same edge; the strobe itself still goes out.
            if (i_cnt_clr) begin
                r_count <= '0;
            end else if (w_tickNext) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_tick               = r_tick;
    assign o_tick_clk           = r_tickClk;
    assign o_tick_count         = r_count;
    assign io_step.o_step_ready = w_stepReady;
    assign io_step.o_busy       = w_busy;
    assign io_step.o_done       = r_done;
    assign io_step.o_steps_left = r_stepsLeft;

endmodule

// File: tb/tb_tps_tick_gen.sv
// Directed bench for tps_tick_gen at ACC_WIDTH=8, STEP_WIDTH=4, CNT_WIDTH=4;
// outputs are sampled 1 time unit after each rising edge.
module tb_tps_tick_gen;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;
    localparam logic [1:0] MAX  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tps;
    logic [1:0] mode;
    logic       cntClr;
    logic       tick;
    logic       tickClk;
    logic [3:0] tickCount;

    int vectors     = 0;
    int miscompares = 0;

    logic       expTick  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] expSteps [6] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
    logic       expDone  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       expBusy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    tps_tick_gen_if #(.STEP_WIDTH(4)) stepIf ();

    tps_tick_gen #(
        .ACC_WIDTH (8),
        .STEP_WIDTH(4),
        .CNT_WIDTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tps       (tps),
        .i_mode      (mode),
        .i_cnt_clr   (cntClr),
        .o_tick      (tick),
        .o_tick_clk  (tickClk),
        .o_tick_count(tickCount),
        .io_step     (stepIf)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] t,
                                 input logic v, input logic [3:0] c, input logic clr);
        mode                = m;
        tps                 = t;
        stepIf.i_step_valid = v;
        stepIf.i_step_count = c;
        cntClr              = clr;
    endtask

    task automatic stepClock(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(STOP, 8'd0, 1'b0, 4'd0, 1'b0);
        stepClock(2);
        checkOutput("rst_tick",     32'(tick), 32'd0);
        checkOutput("rst_tick_clk", 32'(tickClk), 32'd0);
        checkOutput("rst_done",     32'(stepIf.o_done), 32'd0);
        checkOutput("rst_busy",     32'(stepIf.o_busy), 32'd0);
        checkOutput("rst_ready",    32'(stepIf.o_step_ready), 32'd0);
        checkOutput("rst_steps",    32'(stepIf.o_steps_left), 32'd0);
        checkOutput("rst_count",    32'(tickCount), 32'd0);

        // RUN at tps=64 from acc=0: a carry every fourth edge.
        rst = 1'b0;
        applyStimulus(RUN, 8'd64, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            stepClock(1);
            checkOutput("run_tick", 32'(tick), 32'((k % 4) == 0));
        end
        checkOutput("run_count",    32'(tickCount), 32'd3);
        checkOutput("run_tick_clk", 32'(tickClk), 32'd1);

        // Three-tick burst at tps=128.
        applyStimulus(STEP, 8'd128, 1'b1, 4'd3, 1'b0);
        stepClock(1);
        applyStimulus(STEP, 8'd128, 1'b0, 4'd0, 1'b0);
        checkOutput("burst_load_steps", 32'(stepIf.o_steps_left), 32'd3);
        checkOutput("burst_load_busy",  32'(stepIf.o_busy), 32'd1);
        checkOutput("burst_load_ready", 32'(stepIf.o_step_ready), 32'd0);
        checkOutput("burst_load_tick",  32'(tick), 32'd0);
        for (int i = 0; i < 6; i++) begin
            stepClock(1);
            checkOutput("burst_tick",  32'(tick), 32'(expTick[i]));
            checkOutput("burst_steps", 32'(stepIf.o_steps_left), 32'(expSteps[i]));
            checkOutput("burst_done",  32'(stepIf.o_done), 32'(expDone[i]));
            checkOutput("burst_busy",  32'(stepIf.o_busy), 32'(expBusy[i]));
        end
        checkOutput("burst_count",     32'(tickCount), 32'd6);
        checkOutput("burst_end_ready", 32'(stepIf.o_step_ready), 32'd1);

        // Zero-count request accepted during the previous o_done.
        applyStimulus(STEP, 8'd128, 1'b1, 4'd0, 1'b0);
        stepClock(1);
        checkOutput("zero_done",  32'(stepIf.o_done), 32'd1);
        checkOutput("zero_tick",  32'(tick), 32'd0);
        checkOutput("zero_busy",  32'(stepIf.o_busy), 32'd0);
        checkOutput("zero_ready", 32'(stepIf.o_step_ready), 32'd1);
        checkOutput("zero_steps", 32'(stepIf.o_steps_left), 32'd0);

        // Back-to-back one-tick request issued while o_done is high.
        applyStimulus(STEP, 8'd128, 1'b1, 4'd1, 1'b0);
        stepClock(1);
        applyStimulus(STEP, 8'd128, 1'b0, 4'd0, 1'b0);
        checkOutput("b2b_busy",  32'(stepIf.o_busy), 32'd1);
        checkOutput("b2b_done",  32'(stepIf.o_done), 32'd0);
        checkOutput("b2b_steps", 32'(stepIf.o_steps_left), 32'd1);
        stepClock(1);
        checkOutput("b2b_tick_early", 32'(tick), 32'd0);
        stepClock(1);
        checkOutput("b2b_tick",      32'(tick), 32'd1);
        checkOutput("b2b_done_end",  32'(stepIf.o_done), 32'd1);
        checkOutput("b2b_steps_end", 32'(stepIf.o_steps_left), 32'd0);
        checkOutput("b2b_busy_end",  32'(stepIf.o_busy), 32'd0);
        checkOutput("b2b_count",     32'(tickCount), 32'd7);

        // Five-tick burst aborted by STOP after two ticks.
        applyStimulus(STEP, 8'd128, 1'b1, 4'd5, 1'b0);
        stepClock(1);
        applyStimulus(STEP, 8'd128, 1'b0, 4'd0, 1'b0);
        checkOutput("abort_load_steps", 32'(stepIf.o_steps_left), 32'd5);
        stepClock(4);
        checkOutput("abort_pre_tick",  32'(tick), 32'd1);
        checkOutput("abort_pre_steps", 32'(stepIf.o_steps_left), 32'd3);
        checkOutput("abort_pre_count", 32'(tickCount), 32'd9);
        applyStimulus(STOP, 8'd128, 1'b0, 4'd0, 1'b0);
        stepClock(1);
        checkOutput("abort_steps", 32'(stepIf.o_steps_left), 32'd0);
        checkOutput("abort_done",  32'(stepIf.o_done), 32'd0);
        checkOutput("abort_busy",  32'(stepIf.o_busy), 32'd0);
        checkOutput("abort_tick",  32'(tick), 32'd0);
        checkOutput("abort_ready", 32'(stepIf.o_step_ready), 32'd0);
        stepClock(3);
        checkOutput("abort_hold_tick",     32'(tick), 32'd0);
        checkOutput("abort_hold_done",     32'(stepIf.o_done), 32'd0);
        checkOutput("abort_hold_tick_clk", 32'(tickClk), 32'd1);
        checkOutput("abort_hold_count",    32'(tickCount), 32'd9);

        // Same burst, this time killed by reset.
        applyStimulus(STEP, 8'd128, 1'b1, 4'd5, 1'b0);
        stepClock(1);
        applyStimulus(STEP, 8'd128, 1'b0, 4'd0, 1'b0);
        stepClock(4);
        checkOutput("rstb_pre_steps", 32'(stepIf.o_steps_left), 32'd3);
        checkOutput("rstb_pre_busy",  32'(stepIf.o_busy), 32'd1);
        checkOutput("rstb_pre_count", 32'(tickCount), 32'd11);
        rst = 1'b1;
        stepClock(1);
        checkOutput("rstb_tick",     32'(tick), 32'd0);
        checkOutput("rstb_tick_clk", 32'(tickClk), 32'd0);
        checkOutput("rstb_done",     32'(stepIf.o_done), 32'd0);
        checkOutput("rstb_busy",     32'(stepIf.o_busy), 32'd0);
        checkOutput("rstb_ready",    32'(stepIf.o_step_ready), 32'd0);
        checkOutput("rstb_steps",    32'(stepIf.o_steps_left), 32'd0);
        checkOutput("rstb_count",    32'(tickCount), 32'd0);

        // MAX for 17 edges: the 4-bit count wraps through zero.
        rst = 1'b0;
        applyStimulus(MAX, 8'd0, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            stepClock(1);
            checkOutput("max_tick",  32'(tick), 32'd1);
            checkOutput("max_count", 32'(tickCount), 32'(k % 16));
        end
        applyStimulus(MAX, 8'd0, 1'b0, 4'd0, 1'b1);
        stepClock(1);
        checkOutput("clr_tick",  32'(tick), 32'd1);
        checkOutput("clr_count", 32'(tickCount), 32'd0);
        applyStimulus(MAX, 8'd0, 1'b0, 4'd0, 1'b0);
        stepClock(1);
        checkOutput("clr_after_count", 32'(tickCount), 32'd1);

        // Phase preserved across STOP, then a rate change.
        applyStimulus(RUN, 8'd64, 1'b0, 4'd0, 1'b0);
        stepClock(3);
        checkOutput("phase_tick",     32'(tick), 32'd0);
        checkOutput("phase_tick_clk", 32'(tickClk), 32'd1);
        applyStimulus(STOP, 8'd64, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            stepClock(1);
            checkOutput("stop_tick", 32'(tick), 32'd0);
        end
        checkOutput("stop_tick_clk", 32'(tickClk), 32'd1);
        checkOutput("stop_count",    32'(tickCount), 32'd1);
        applyStimulus(RUN, 8'd64, 1'b0, 4'd0, 1'b0);
        stepClock(1);
        checkOutput("resume_tick",  32'(tick), 32'd1);
        checkOutput("resume_count", 32'(tickCount), 32'd2);
        applyStimulus(RUN, 8'd32, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            stepClock(1);
            checkOutput("rate_tick", 32'(tick), 32'((k % 8) == 0));
        end
        checkOutput("rate_count", 32'(tickCount), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tps_tick_gen.md
Name: tps_tick_gen

Overview:
- Multi-mode redstone tick generator; next generation of the tps clock divider.
- A parametrised phase accumulator turns a per-cycle increment (i_tps) into tick strobes.
- Adds run/stop/step-burst/max-speed modes, a step-command handshake and a wrapping tick counter.
- Sits between the host command interface and the redstone simulation core, which advances one game tick per o_tick.

Parameters:
- ACC_WIDTH, 32, width of the phase accumulator and i_tps; tick rate = f_clk * i_tps / 2^ACC_WIDTH.
- STEP_WIDTH, 16, width of the step-burst count.
- CNT_WIDTH, 32, width of the total tick counter.

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_tps  in  ACC_WIDTH  phase increment per cycle; sampled every cycle.
- i_mode  in  2  00 STOP, 01 RUN, 10 STEP, 11 MAX.
- i_step_valid  in  1  step-burst request valid.
- i_step_count  in  STEP_WIDTH  number of ticks requested; qualified by i_step_valid.
- o_step_ready  out  1  high when a burst can be accepted.
- i_cnt_clr  in  1  synchronous clear of o_tick_count.
- o_tick  out  1  one-cycle tick strobe.
- o_tick_clk  out  1  registered accumulator MSB, a ~50% duty tick clock.
- o_busy  out  1  high while a step burst is in progress.
- o_done  out  1  one-cycle pulse when a burst completes.
- o_steps_left  out  STEP_WIDTH  remaining ticks in the current burst.
- o_tick_count  out  CNT_WIDTH  total ticks emitted, modulo 2^CNT_WIDTH.

Behaviour:
- Reset (i_rst high at an edge) sets:
  - acc = 0, steps_left = 0, o_tick_count = 0;
  - o_tick = 0, o_tick_clk = 0, o_done = 0, o_busy = 0, o_step_ready = 0.
- Reset overrides all other inputs, including mid-burst. A burst in flight is discarded with no o_done.
- Accumulator:
  - When advancing: {carry, acc} <= acc + i_tps, an ACC_WIDTH+1-bit add with unsigned wrap.
  - carry = 1 generates a tick.
  - When not advancing, acc holds its value; phase is preserved across STOP.
- Tick latency: a carry produced at edge t drives o_tick high for exactly the cycle after edge t. o_tick_count increments at that same edge.
- STOP (00):
  - acc holds; no ticks; o_tick_clk holds.
  - o_step_ready = 0.
- RUN (01):
  - acc advances every cycle; tick on every carry.
  - i_tps = 0 gives no ticks.
  - An all-ones i_tps gives a tick on all but one cycle per 2^ACC_WIDTH.
- MAX (11):
  - o_tick is high every cycle; acc holds.
  - o_tick_count increments every cycle.
- STEP (10) FSM, states IDLE and BURST:
  - IDLE: o_step_ready = 1, o_busy = 0, acc holds. A handshake (i_step_valid & o_step_ready) at an edge loads steps_left = i_step_count.
    - Nonzero count: go to BURST.
    - Zero count: pulse o_done in the next cycle, stay in IDLE, emit no ticks.
  - BURST: o_step_ready = 0, o_busy = 1, acc advances. Each carry emits a tick and decrements steps_left.
  - On the carry that takes steps_left from 1 to 0: o_done pulses in the same cycle as that final o_tick, and the FSM returns to IDLE.
  - The next request can be accepted in the cycle o_done is high.
  - i_step_valid while not ready is ignored; it is not queued.
  - i_tps = 0 in BURST stalls indefinitely with o_busy held high.
- Mode change:
  - Takes effect at the next edge.
  - Leaving STEP while in BURST aborts the burst: steps_left = 0, FSM to IDLE, no o_done.
  - A carry computed on the same edge as the mode change is still delivered.
- o_tick_clk <= acc[ACC_WIDTH-1] (pre-add value), registered every cycle in which acc advances.
- Counter:
  - o_tick_count wraps from all-ones to 0.
  - i_cnt_clr has priority over a simultaneous tick: the count becomes 0 and that tick is not counted. o_tick itself is still emitted.
- i_tps may change on any cycle; the new value is used in the next add, with no glitch or lost phase.

Test Plan:
All cases use ACC_WIDTH=8, STEP_WIDTH=4, CNT_WIDTH=4.
- RUN tick rate: reset, mode=RUN, tps=64 from acc=0 -> o_tick high on cycles 4, 8, 12, ... after the first advancing edge, each for 1 cycle; o_tick_count=3 after 12 cycles.
- Step burst: mode=STEP, tps=128, request count=3 -> ticks on cycles 2, 4, 6 after acceptance.
  - o_done coincides with the third tick.
  - o_steps_left goes 3, 2, 1, 0; o_busy drops and o_step_ready rises with o_done.
- Zero-count and back-to-back requests:
  - count=0 -> o_done the next cycle with no tick.
  - A second request (count=1) asserted during o_done -> accepted, one tick.
- Abort and reset mid-burst:
  - count=5 with tps=128; after 2 ticks switch to STOP -> o_steps_left=0, no o_done, acc frozen.
  - Repeat with i_rst instead -> all outputs return to reset values.
- MAX mode and counter wrap: mode=MAX for 17 cycles -> o_tick high for 17 consecutive cycles; o_tick_count=1 (wrapped at 16).
  - Assert i_cnt_clr on the same cycle as a tick -> count=0.
- Rate change and STOP phase hold:
  - RUN with tps=64; stop with acc=192, idle 10 cycles, resume -> first tick 1 cycle after resuming.
  - Switch to tps=32 -> subsequent ticks every 8 cycles.
